// File: rtl/rtc_io_manager.sv
// CPU-mapped misc/IO slave: calendar clock with carry/leap rules plus a byte rx FIFO.
// All CPU reads return through a single registered result port.
module rtc_io_manager #(
  parameter int DATA_W        = 16,
  parameter int TICKS_PER_SEC = 100,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cs,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] port,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              tick_sec
);

  localparam logic [3:0] OP_IN   = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_TIME = 4'b0100;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICKS_PER_SEC - 1);

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic              rx_ready_reg;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              tick_reg, tick_next;
  logic [PW-1:0]     prescaler_reg, prescaler_next;
  logic [DATA_W-1:0] sec_reg, min_reg, hour_reg, day_reg, month_reg, year_reg;
  logic [DATA_W-1:0] sec_next, min_next, hour_next, day_next, month_next, year_next;

  logic is_in, is_out, is_time, wr_time, push, pop, fifo_empty;

  function automatic logic [DATA_W-1:0] days_in_month(input logic [DATA_W-1:0] m,
                                                       input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] d;
    case (m)
      DATA_W'(4), DATA_W'(6), DATA_W'(9), DATA_W'(11): d = DATA_W'(30);
      DATA_W'(2): d = (y[1:0] == 2'b00) ? DATA_W'(29) : DATA_W'(28);
      default:    d = DATA_W'(31);
    endcase
    return d;
  endfunction

  assign is_in      = cs && (op == OP_IN);
  assign is_out     = cs && (op == OP_OUT);
  assign is_time    = cs && (op == OP_TIME);
  assign wr_time    = is_out && (port < DATA_W'(6));
  assign fifo_empty = (count_reg == '0);
  assign push       = rx_valid && rx_ready_reg;
  // An empty pop is refused even if a push lands the same cycle; that byte stays stored.
  assign pop        = is_in && (port == '0) && !fifo_empty;
  assign count_next = count_reg + CW'(push) - CW'(pop);

  always_comb begin
    result_next = '0;
    if (is_in) begin
      if (port == '0)
        result_next = fifo_empty ? '1 : {{(DATA_W-8){1'b0}}, fifo_mem[rd_ptr_reg]};
      else if (port == DATA_W'(1))
        result_next = {{(DATA_W-CW){1'b0}}, count_reg};
    end else if (is_time) begin
      case (port)
        DATA_W'(0): result_next = sec_reg;
        DATA_W'(1): result_next = min_reg;
        DATA_W'(2): result_next = hour_reg;
        DATA_W'(3): result_next = day_reg;
        DATA_W'(4): result_next = month_reg;
        DATA_W'(5): result_next = year_reg;
        default:    result_next = '0;
      endcase
    end
  end

  // Field writes restart the second and swallow a coinciding tick; out-of-range values
  // use >= so they wrap to their minimum on the next increment.
  always_comb begin
    prescaler_next = prescaler_reg + PW'(1);
    tick_next      = 1'b0;
    sec_next       = sec_reg;
    min_next       = min_reg;
    hour_next      = hour_reg;
    day_next       = day_reg;
    month_next     = month_reg;
    year_next      = year_reg;
    if (wr_time) begin
      prescaler_next = '0;
      case (port[2:0])
        3'd0:    sec_next   = data;
        3'd1:    min_next   = data;
        3'd2:    hour_next  = data;
        3'd3:    day_next   = data;
        3'd4:    month_next = data;
        default: year_next  = data;
      endcase
    end else if (prescaler_reg == PRESCALE_MAX) begin
      prescaler_next = '0;
      tick_next      = 1'b1;
      if (sec_reg >= DATA_W'(59)) begin
        sec_next = '0;
        if (min_reg >= DATA_W'(59)) begin
          min_next = '0;
          if (hour_reg >= DATA_W'(23)) begin
            hour_next = '0;
            if (day_reg >= days_in_month(month_reg, year_reg)) begin
              day_next = DATA_W'(1);
              if (month_reg >= DATA_W'(12)) begin
                month_next = DATA_W'(1);
                year_next  = year_reg + DATA_W'(1);
              end else begin
                month_next = month_reg + DATA_W'(1);
              end
            end else begin
              day_next = day_reg + DATA_W'(1);
            end
          end else begin
            hour_next = hour_reg + DATA_W'(1);
          end
        end else begin
          min_next = min_reg + DATA_W'(1);
        end
      end else begin
        sec_next = sec_reg + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rx_ready_reg  <= 1'b1;
      result_reg    <= '0;
      tick_reg      <= 1'b0;
      prescaler_reg <= '0;
      sec_reg       <= '0;
      min_reg       <= '0;
      hour_reg      <= '0;
      day_reg       <= DATA_W'(1);
      month_reg     <= DATA_W'(1);
      year_reg      <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg     <= count_next;
      rx_ready_reg  <= (count_next != CW'(FIFO_DEPTH));
      result_reg    <= result_next;
      tick_reg      <= tick_next;
      prescaler_reg <= prescaler_next;
      sec_reg       <= sec_next;
      min_reg       <= min_next;
      hour_reg      <= hour_next;
      day_reg       <= day_next;
      month_reg     <= month_next;
      year_reg      <= year_next;
    end
  end

  assign result   = result_reg;
  assign rx_ready = rx_ready_reg;
  assign tick_sec = tick_reg;

endmodule

// File: tb/tb_rtc_io_manager.sv
// Directed self-checking bench for rtc_io_manager: reset, FIFO flow control, calendar carries.
module tb_rtc_io_manager;
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_IN   = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_TIME = 4'b0100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cs = 1'b0;
  logic [3:0]  op = OP_NOP;
  logic [15:0] port = '0;
  logic [15:0] data = '0;
  logic [15:0] result;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        tick_sec;

  int tests = 0;
  int fails = 0;
  int ticks, last_k;

  rtc_io_manager #(.DATA_W(16), .TICKS_PER_SEC(100), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .cs(cs), .op(op), .port(port), .data(data),
    .result(result), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tick_sec(tick_sec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one CPU op for a single cycle; returns at the negedge after it was sampled.
  task automatic do_op(input logic [3:0] o, input logic [15:0] p, input logic [15:0] d);
    cs = 1'b1; op = o; port = p; data = d;
    @(negedge clk);
    cs = 1'b0; op = OP_NOP; port = '0; data = '0;
  endtask

  task automatic rd_time(input string tag, input logic [15:0] p, input logic [15:0] exp);
    do_op(OP_TIME, p, 16'h0);
    chk(tag, {16'h0, result}, {16'h0, exp});
  endtask

  task automatic set_time(input logic [15:0] s, input logic [15:0] mi, input logic [15:0] h,
                          input logic [15:0] d, input logic [15:0] mo, input logic [15:0] y);
    do_op(OP_OUT, 16'd0, s);
    do_op(OP_OUT, 16'd1, mi);
    do_op(OP_OUT, 16'd2, h);
    do_op(OP_OUT, 16'd3, d);
    do_op(OP_OUT, 16'd4, mo);
    do_op(OP_OUT, 16'd5, y);
  endtask

  task automatic run_cycles(input int n, output int t, output int last);
    t = 0; last = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (tick_sec) begin t++; last = k; end
    end
  endtask

  initial begin
    // Reset values, then field reads
    repeat (3) @(negedge clk);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("rst_tick", {31'h0, tick_sec}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    rd_time("rst_sec", 16'd0, 16'd0);
    rd_time("rst_min", 16'd1, 16'd0);
    rd_time("rst_hour", 16'd2, 16'd0);
    rd_time("rst_day", 16'd3, 16'd1);
    rd_time("rst_month", 16'd4, 16'd1);
    rd_time("rst_year", 16'd5, 16'd0);
    rd_time("time_bad_port", 16'd6, 16'd0);

    // Two pushes, count, pops, empty pop
    rx_valid = 1'b1; rx_data = 8'h41;
    @(negedge clk);
    rx_data = 8'h42;
    @(negedge clk);
    rx_valid = 1'b0;
    cs = 1'b0; op = OP_IN; port = 16'd1;
    @(negedge clk);
    op = OP_NOP; port = '0;
    chk("cs_low_nop", {16'h0, result}, 32'h0);
    do_op(OP_IN, 16'd1, 16'h0);
    chk("in_count2", {16'h0, result}, 32'h2);
    do_op(OP_IN, 16'd0, 16'h0);
    chk("pop_41", {16'h0, result}, 32'h41);
    do_op(OP_NOP, 16'd0, 16'h0);
    chk("nop_zero", {16'h0, result}, 32'h0);
    do_op(OP_IN, 16'd0, 16'h0);
    chk("pop_42", {16'h0, result}, 32'h42);
    do_op(OP_IN, 16'd0, 16'h0);
    chk("pop_empty", {16'h0, result}, 32'hFFFF);
    do_op(OP_IN, 16'd2, 16'h0);
    chk("in_bad_port", {16'h0, result}, 32'h0);

    // Fill to full, hold off 9th byte, pop re-raises rx_ready a cycle later
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    rx_data = 8'h99;
    chk("full_rx_ready", {31'h0, rx_ready}, 32'h0);
    do_op(OP_IN, 16'd1, 16'h0);
    chk("full_count", {16'h0, result}, 32'h8);
    do_op(OP_IN, 16'd0, 16'h0);
    chk("full_pop_10", {16'h0, result}, 32'h10);
    chk("ready_after_pop", {31'h0, rx_ready}, 32'h1);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("refull_rx_ready", {31'h0, rx_ready}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      do_op(OP_IN, 16'd0, 16'h0);
      chk("drain", {16'h0, result}, 32'(8'h11 + i));
    end
    do_op(OP_IN, 16'd0, 16'h0);
    chk("drain_99", {16'h0, result}, 32'h99);
    do_op(OP_IN, 16'd0, 16'h0);
    chk("drain_empty", {16'h0, result}, 32'hFFFF);

    // Pop on empty with simultaneous push: all-ones returned, byte kept
    rx_valid = 1'b1; rx_data = 8'h5A;
    do_op(OP_IN, 16'd0, 16'h0);
    rx_valid = 1'b0;
    chk("pushpop_empty", {16'h0, result}, 32'hFFFF);
    do_op(OP_IN, 16'd1, 16'h0);
    chk("pushpop_count", {16'h0, result}, 32'h1);
    do_op(OP_IN, 16'd0, 16'h0);
    chk("pushpop_byte", {16'h0, result}, 32'h5A);

    // New Year rollover
    set_time(16'd59, 16'd59, 16'd23, 16'd31, 16'd12, 16'd2023);
    chk("out_result", {16'h0, result}, 32'h0);
    run_cycles(100, ticks, last_k);
    chk("ny_ticks", 32'(ticks), 32'd1);
    chk("ny_tick_at", 32'(last_k), 32'd100);
    rd_time("ny_sec", 16'd0, 16'd0);
    rd_time("ny_min", 16'd1, 16'd0);
    rd_time("ny_hour", 16'd2, 16'd0);
    rd_time("ny_day", 16'd3, 16'd1);
    rd_time("ny_month", 16'd4, 16'd1);
    rd_time("ny_year", 16'd5, 16'd2024);

    // Leap year: 28 Feb -> 29 Feb; non-leap: 28 Feb -> 1 Mar
    set_time(16'd59, 16'd59, 16'd23, 16'd28, 16'd2, 16'd2024);
    run_cycles(100, ticks, last_k);
    rd_time("leap_day", 16'd3, 16'd29);
    rd_time("leap_month", 16'd4, 16'd2);
    set_time(16'd59, 16'd59, 16'd23, 16'd28, 16'd2, 16'd2023);
    run_cycles(100, ticks, last_k);
    rd_time("nonleap_day", 16'd3, 16'd1);
    rd_time("nonleap_month", 16'd4, 16'd3);
    rd_time("nonleap_year", 16'd5, 16'd2023);
    // 30 Apr -> 1 May
    set_time(16'd59, 16'd59, 16'd23, 16'd30, 16'd4, 16'd2001);
    run_cycles(100, ticks, last_k);
    rd_time("apr_day", 16'd3, 16'd1);
    rd_time("apr_month", 16'd4, 16'd5);

    // Out-of-range seconds wrap to 0 and carry into minutes
    set_time(16'd75, 16'd5, 16'd10, 16'd15, 16'd6, 16'd2000);
    run_cycles(100, ticks, last_k);
    rd_time("oor_sec", 16'd0, 16'd0);
    rd_time("oor_min", 16'd1, 16'd6);

    // Write on the wrap cycle drops the tick and restarts the second
    set_time(16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd0);
    run_cycles(99, ticks, last_k);
    chk("prewrap_ticks", 32'(ticks), 32'd0);
    do_op(OP_OUT, 16'd0, 16'd7);
    chk("wrap_write_tick", {31'h0, tick_sec}, 32'h0);
    run_cycles(100, ticks, last_k);
    chk("wrap_ticks", 32'(ticks), 32'd1);
    chk("wrap_tick_at", 32'(last_k), 32'd100);
    rd_time("wrap_sec", 16'd0, 16'd8);

    // Asynchronous reset mid-operation drops FIFO contents
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    do_op(OP_IN, 16'd1, 16'h0);
    chk("prereset_count", {16'h0, result}, 32'h8);
    rstn = 1'b0;
    #1;
    chk("async_result", {16'h0, result}, 32'h0);
    chk("async_rx_ready", {31'h0, rx_ready}, 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    do_op(OP_IN, 16'd1, 16'h0);
    chk("postreset_count", {16'h0, result}, 32'h0);
    do_op(OP_IN, 16'd0, 16'h0);
    chk("postreset_pop", {16'h0, result}, 32'hFFFF);
    rd_time("postreset_day", 16'd3, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
